// File: rtl/axi_node_pkg.sv
// rtl/axi_node_pkg.sv - shared types and helpers for the AXI node port stages
package axi_node_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        QUIESCED = 2'd2
    } quiesce_state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/axi_bus.sv
// rtl/axi_bus.sv - AXI4 bus interface with master and slave views
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]         w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/axi_txn_counter.sv
// rtl/axi_txn_counter.sv - saturating-at-zero outstanding transaction counter
module axi_txn_counter
    import axi_node_pkg::*;
#(
    parameter int unsigned MAX   = 8,
    parameter int unsigned CNT_W = cnt_width(MAX)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             nxt_zero_o,
    output logic             full_o,
    output logic             zero_o,
    output logic             underflow_o
);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d       = cnt_q;
        underflow_o = 1'b0;
        if (inc_i && !dec_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_i && !inc_i) begin
            // A stray response at zero passes through; the count holds.
            if (cnt_q == '0) begin
                underflow_o = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign nxt_zero_o = (cnt_d == '0);
    assign full_o     = (cnt_q == MAX_C);
    assign zero_o     = (cnt_q == '0);

endmodule

// File: rtl/axi_outstanding_limiter.sv
// rtl/axi_outstanding_limiter.sv - caps outstanding AXI reads/writes and drains a port on request
module axi_outstanding_limiter
    import axi_node_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter int unsigned AXI_USER_WIDTH = 1,
    parameter int unsigned MAX_RD_TXN     = 8,
    parameter int unsigned MAX_WR_TXN     = 8,
    localparam int unsigned CNT_W =
        cnt_width((MAX_RD_TXN > MAX_WR_TXN) ? MAX_RD_TXN : MAX_WR_TXN)
) (
    input  logic             clk,
    input  logic             rst_n,
    AXI_BUS.Slave            slave,
    AXI_BUS.Master           master,
    input  logic             quiesce_req_i,
    output logic             quiesce_ack_o,
    output logic [CNT_W-1:0] rd_outstanding_o,
    output logic [CNT_W-1:0] wr_outstanding_o,
    output logic             err_o
);
    if (MAX_RD_TXN < 1 || MAX_WR_TXN < 1 || AXI_ADDR_WIDTH < 1 ||
        AXI_DATA_WIDTH < 8 || AXI_ID_WIDTH < 1 || AXI_USER_WIDTH < 1) begin : g_param_err
        $error("axi_outstanding_limiter: illegal parameter value");
    end

    quiesce_state_t state_d, state_q;
    logic           err_d, err_q;

    logic rd_inc, rd_dec, rd_full, rd_zero, rd_nxt_zero, rd_uf;
    logic wr_inc, wr_dec, wr_full, wr_zero, wr_nxt_zero, wr_uf;
    logic rd_block, wr_block;

    // Blocks come from registers only, so no valid ever depends on a ready.
    assign rd_block = rd_full | (state_q != RUN);
    assign wr_block = wr_full | (state_q != RUN);

    assign rd_inc = master.ar_valid & master.ar_ready;
    assign rd_dec = slave.r_valid & slave.r_ready & slave.r_last;
    assign wr_inc = master.aw_valid & master.aw_ready;
    assign wr_dec = slave.b_valid & slave.b_ready;

    axi_txn_counter #(.MAX(MAX_RD_TXN), .CNT_W(CNT_W)) u_rd_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_i       (rd_inc),
        .dec_i       (rd_dec),
        .cnt_o       (rd_outstanding_o),
        .nxt_zero_o  (rd_nxt_zero),
        .full_o      (rd_full),
        .zero_o      (rd_zero),
        .underflow_o (rd_uf)
    );

    axi_txn_counter #(.MAX(MAX_WR_TXN), .CNT_W(CNT_W)) u_wr_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_i       (wr_inc),
        .dec_i       (wr_dec),
        .cnt_o       (wr_outstanding_o),
        .nxt_zero_o  (wr_nxt_zero),
        .full_o      (wr_full),
        .zero_o      (wr_zero),
        .underflow_o (wr_uf)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q | rd_uf | wr_uf;
        unique case (state_q)
            RUN: begin
                if (quiesce_req_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (!quiesce_req_i) begin
                    state_d = RUN;
                end else if (rd_nxt_zero && wr_nxt_zero) begin
                    state_d = QUIESCED;
                end
            end
            QUIESCED: begin
                if (!quiesce_req_i) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign quiesce_ack_o = (state_q == QUIESCED);
    assign err_o         = err_q;

    assign master.aw_id     = slave.aw_id;
    assign master.aw_addr   = slave.aw_addr;
    assign master.aw_len    = slave.aw_len;
    assign master.aw_size   = slave.aw_size;
    assign master.aw_burst  = slave.aw_burst;
    assign master.aw_lock   = slave.aw_lock;
    assign master.aw_cache  = slave.aw_cache;
    assign master.aw_prot   = slave.aw_prot;
    assign master.aw_qos    = slave.aw_qos;
    assign master.aw_region = slave.aw_region;
    assign master.aw_user   = slave.aw_user;
    assign master.aw_valid  = slave.aw_valid & ~wr_block;
    assign slave.aw_ready   = master.aw_ready & ~wr_block;

    assign master.w_data  = slave.w_data;
    assign master.w_strb  = slave.w_strb;
    assign master.w_last  = slave.w_last;
    assign master.w_user  = slave.w_user;
    assign master.w_valid = slave.w_valid;
    assign slave.w_ready  = master.w_ready;

    assign slave.b_id     = master.b_id;
    assign slave.b_resp   = master.b_resp;
    assign slave.b_user   = master.b_user;
    assign slave.b_valid  = master.b_valid;
    assign master.b_ready = slave.b_ready;

    assign master.ar_id     = slave.ar_id;
    assign master.ar_addr   = slave.ar_addr;
    assign master.ar_len    = slave.ar_len;
    assign master.ar_size   = slave.ar_size;
    assign master.ar_burst  = slave.ar_burst;
    assign master.ar_lock   = slave.ar_lock;
    assign master.ar_cache  = slave.ar_cache;
    assign master.ar_prot   = slave.ar_prot;
    assign master.ar_qos    = slave.ar_qos;
    assign master.ar_region = slave.ar_region;
    assign master.ar_user   = slave.ar_user;
    assign master.ar_valid  = slave.ar_valid & ~rd_block;
    assign slave.ar_ready   = master.ar_ready & ~rd_block;

    assign slave.r_id     = master.r_id;
    assign slave.r_data   = master.r_data;
    assign slave.r_resp   = master.r_resp;
    assign slave.r_last   = master.r_last;
    assign slave.r_user   = master.r_user;
    assign slave.r_valid  = master.r_valid;
    assign master.r_ready = slave.r_ready;

endmodule

// File: tb/tb_axi_outstanding_limiter.sv
// tb/tb_axi_outstanding_limiter.sv - directed self-checking bench for axi_outstanding_limiter
module tb_axi_outstanding_limiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       quiesce_req = 1'b0;
    logic       quiesce_ack;
    logic [3:0] rd_out;
    logic [3:0] wr_out;
    logic       err;

    int n_vec = 0;
    int n_err = 0;

    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(1)) up ();
    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(1)) dn ();

    axi_outstanding_limiter #(
        .AXI_ADDR_WIDTH (32),
        .AXI_DATA_WIDTH (32),
        .AXI_ID_WIDTH   (10),
        .AXI_USER_WIDTH (1),
        .MAX_RD_TXN     (2),
        .MAX_WR_TXN     (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .slave            (up),
        .master           (dn),
        .quiesce_req_i    (quiesce_req),
        .quiesce_ack_o    (quiesce_ack),
        .rd_outstanding_o (rd_out),
        .wr_outstanding_o (wr_out),
        .err_o            (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        up.aw_id = '0; up.aw_addr = '0; up.aw_len = '0; up.aw_size = '0; up.aw_burst = '0;
        up.aw_lock = 1'b0; up.aw_cache = '0; up.aw_prot = '0; up.aw_qos = '0; up.aw_region = '0;
        up.aw_user = '0; up.aw_valid = 1'b0;
        up.w_data = '0; up.w_strb = '0; up.w_last = 1'b0; up.w_user = '0; up.w_valid = 1'b0;
        up.b_ready = 1'b0;
        up.ar_id = '0; up.ar_addr = '0; up.ar_len = '0; up.ar_size = '0; up.ar_burst = '0;
        up.ar_lock = 1'b0; up.ar_cache = '0; up.ar_prot = '0; up.ar_qos = '0; up.ar_region = '0;
        up.ar_user = '0; up.ar_valid = 1'b0;
        up.r_ready = 1'b0;
        dn.aw_ready = 1'b0; dn.w_ready = 1'b0;
        dn.b_id = '0; dn.b_resp = '0; dn.b_user = '0; dn.b_valid = 1'b0;
        dn.ar_ready = 1'b0;
        dn.r_id = '0; dn.r_data = '0; dn.r_resp = '0; dn.r_last = 1'b0; dn.r_user = '0;
        dn.r_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        clear_inputs();
        tick();
        tick();
        check("rst_rd_cnt", rd_out, 0);
        check("rst_wr_cnt", wr_out, 0);
        check("rst_ack", quiesce_ack, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        // Read cap of 2: two ARs accepted, third stalls until an R last returns.
        dn.ar_ready = 1'b1; up.ar_valid = 1'b1; up.ar_addr = 32'h1234_5678;
        up.r_ready = 1'b1;
        #1;
        check("ar_ready_empty", up.ar_ready, 1);
        check("ar_addr_pass", dn.ar_addr, 32'h1234_5678);
        tick();
        check("rd_cnt_1", rd_out, 1);
        tick();
        check("rd_cnt_full", rd_out, 2);
        #1;
        check("ar_ready_full", up.ar_ready, 0);
        check("ar_valid_full", dn.ar_valid, 0);
        tick();
        check("rd_cnt_hold", rd_out, 2);
        dn.r_valid = 1'b1; dn.r_last = 1'b1; dn.r_data = 32'hCAFE_0001;
        #1;
        check("r_data_pass", up.r_data, 32'hCAFE_0001);
        check("ar_ready_same_cyc", up.ar_ready, 0);
        tick();
        dn.r_valid = 1'b0;
        check("rd_cnt_after_r", rd_out, 1);
        #1;
        check("ar_ready_reopen", up.ar_ready, 1);
        tick();
        up.ar_valid = 1'b0;
        check("rd_cnt_third", rd_out, 2);
        dn.r_valid = 1'b1;
        tick();
        tick();
        dn.r_valid = 1'b0;
        check("rd_cnt_drained", rd_out, 0);

        // 4-beat burst: only the last beat decrements.
        up.ar_valid = 1'b1;
        tick();
        up.ar_valid = 1'b0;
        dn.r_valid = 1'b1; dn.r_last = 1'b0;
        for (int b = 0; b < 3; b++) begin
            tick();
            check("burst_mid_beat", rd_out, 1);
        end
        dn.r_last = 1'b1;
        tick();
        dn.r_valid = 1'b0;
        check("burst_last_beat", rd_out, 0);

        // Writes to 3, then simultaneous AW and B with a concurrent AR.
        dn.aw_ready = 1'b1; up.aw_valid = 1'b1; up.w_valid = 1'b1; up.w_data = 32'hA5A5_5A5A;
        #1;
        check("w_valid_pass", dn.w_valid, 1);
        check("w_data_pass", dn.w_data, 32'hA5A5_5A5A);
        tick(); tick(); tick();
        up.w_valid = 1'b0;
        check("wr_cnt_3", wr_out, 3);
        dn.b_valid = 1'b1; up.b_ready = 1'b1; up.ar_valid = 1'b1;
        tick();
        up.aw_valid = 1'b0; up.ar_valid = 1'b0;
        check("wr_cnt_inc_dec", wr_out, 3);
        check("rd_cnt_unaffected", rd_out, 1);
        tick(); tick(); tick();
        dn.b_valid = 1'b0;
        check("wr_cnt_drained", wr_out, 0);
        dn.r_valid = 1'b1;
        tick();
        dn.r_valid = 1'b0;
        check("rd_cnt_zero_again", rd_out, 0);

        // Quiesce with one read outstanding.
        up.ar_valid = 1'b1;
        tick();
        up.ar_valid = 1'b0;
        check("q_rd_cnt_1", rd_out, 1);
        quiesce_req = 1'b1;
        tick();
        up.ar_valid = 1'b1;
        #1;
        check("q_ar_blocked", up.ar_ready, 0);
        check("q_ar_valid_blocked", dn.ar_valid, 0);
        check("q_ack_drain", quiesce_ack, 0);
        tick();
        check("q_ack_still_drain", quiesce_ack, 0);
        dn.r_valid = 1'b1;
        tick();
        dn.r_valid = 1'b0;
        check("q_ack_set", quiesce_ack, 1);
        check("q_rd_cnt_0", rd_out, 0);
        tick();
        check("q_no_ar_counted", rd_out, 0);
        quiesce_req = 1'b0;
        #1;
        check("q_ack_before_edge", quiesce_ack, 1);
        tick();
        check("q_ack_drop", quiesce_ack, 0);
        #1;
        check("q_ar_reopen", up.ar_ready, 1);
        tick();
        up.ar_valid = 1'b0;
        check("q_ar_accepted", rd_out, 1);
        dn.r_valid = 1'b1;
        tick();
        dn.r_valid = 1'b0;

        // Idle-port ack latency is 2 cycles; AR in the request cycle is counted.
        up.ar_valid = 1'b1; quiesce_req = 1'b1;
        #1;
        check("req_cyc_ar_ready", up.ar_ready, 1);
        tick();
        up.ar_valid = 1'b0;
        check("req_cyc_ar_counted", rd_out, 1);
        dn.r_valid = 1'b1;
        tick();
        dn.r_valid = 1'b0;
        check("ack_after_drain", quiesce_ack, 1);
        quiesce_req = 1'b0;
        tick();
        quiesce_req = 1'b1;
        tick();
        check("idle_ack_n1", quiesce_ack, 0);
        tick();
        check("idle_ack_n2", quiesce_ack, 1);
        quiesce_req = 1'b0;
        tick();
        check("idle_ack_release", quiesce_ack, 0);
        quiesce_req = 1'b1;
        tick();
        quiesce_req = 1'b0;
        tick();
        check("abort_no_ack_0", quiesce_ack, 0);
        tick();
        check("abort_no_ack_1", quiesce_ack, 0);
        up.ar_valid = 1'b1;
        #1;
        check("abort_ar_ready", up.ar_ready, 1);
        up.ar_valid = 1'b0;

        // Stray B at zero: sticky error, count holds at 0.
        dn.b_valid = 1'b1; dn.b_resp = 2'b10;
        #1;
        check("stray_b_pass", up.b_valid, 1);
        check("b_resp_pass", up.b_resp, 2'b10);
        tick();
        dn.b_valid = 1'b0;
        check("err_set", err, 1);
        check("err_wr_cnt_0", wr_out, 0);
        tick(); tick();
        check("err_sticky", err, 1);

        // Asynchronous reset mid-transaction clears everything.
        up.ar_valid = 1'b1; up.aw_valid = 1'b1;
        tick();
        up.ar_valid = 1'b0; up.aw_valid = 1'b0; quiesce_req = 1'b1;
        check("pre_rst_rd", rd_out, 1);
        check("pre_rst_wr", wr_out, 1);
        dn.r_valid = 1'b1; dn.r_last = 1'b0;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd", rd_out, 0);
        check("mid_rst_wr", wr_out, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_ack", quiesce_ack, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
